// File: rtl/shift_reg_univ.sv
// shift_reg_univ
//   WIDTH-bit universal register: hold, parallel load, logical shift left/right,
//   rotate left/right and arithmetic shift right. A start request with a
//   shift/rotate mode runs a burst of 'amount' steps, one per enabled clock,
//   reported through busy and a one-cycle done pulse.
//
// Ports
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   en       clock enable; low freezes q, state and burst counter
//   mode     operation select (000 hold, 001 load, 010 shl, 011 shr,
//            100 rol, 101 ror, 110 asr, 111 hold)
//   d        parallel load data
//   sin_l    serial input entering at the MSB on shr
//   sin_r    serial input entering at the LSB on shl
//   start    burst request
//   amount   burst length in positions
//   q        register contents
//   sout_l   q MSB
//   sout_r   q LSB
//   busy     burst in progress
//   done     one-cycle pulse when a burst finishes
//
// State | meaning
// IDLE  | single-step mode, waiting for a burst request
// BUSY  | burst running, one latched-mode step per enabled clock

module shift_reg_univ #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    localparam int              AMT_W     = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [AMT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       lmode, lmode_nxt;
    logic             done_nxt;
    logic             burst_mode;

    function automatic logic [WIDTH-1:0] step_q(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] ld,
        input logic             sl,
        input logic             sr
    );
        logic [WIDTH-1:0] r;
        case (m)
            3'b001:  r = ld;
            3'b010:  r = {cur[WIDTH-2:0], sr};
            3'b011:  r = {sl, cur[WIDTH-1:1]};
            3'b100:  r = {cur[WIDTH-2:0], cur[WIDTH-1]};
            3'b101:  r = {cur[0], cur[WIDTH-1:1]};
            3'b110:  r = {cur[WIDTH-1], cur[WIDTH-1:1]};
            default: r = cur;
        endcase
        return r;
    endfunction

    // Only the shift/rotate modes can start a burst; hold/load/reserved
    // with start fall through to a plain single step.
    assign burst_mode = (mode >= 3'b010) && (mode <= 3'b110);

    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        cnt_nxt   = cnt;
        lmode_nxt = lmode;
        done_nxt  = 1'b0;
        if (en) begin
            case (state)
                IDLE: begin
                    if (start && burst_mode) begin
                        lmode_nxt = mode;
                        cnt_nxt   = amount;
                        if (amount != '0) begin
                            state_nxt = BUSY;
                        end else begin
                            done_nxt = 1'b1;
                        end
                    end else begin
                        q_nxt = step_q(mode, q, d, sin_l, sin_r);
                    end
                end
                BUSY: begin
                    q_nxt   = step_q(lmode, q, d, sin_l, sin_r);
                    cnt_nxt = cnt - AMT_W'(1);
                    if (cnt == AMT_W'(1)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // done is rewritten every edge, so a disabled edge always clears it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            q     <= RESET_VAL;
            cnt   <= '0;
            lmode <= 3'b000;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            q     <= q_nxt;
            cnt   <= cnt_nxt;
            lmode <= lmode_nxt;
            done  <= done_nxt;
        end
    end

    assign busy   = (state == BUSY);
    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed-vector bench for shift_reg_univ (WIDTH=8, RESET_VAL=0).
// Inputs change 1 ns after a rising edge; outputs are checked at the same point.

module tb_shift_reg_univ;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin_l;
    logic       sin_r;
    logic       start;
    logic [3:0] amount;
    logic [7:0] q;
    logic       sout_l;
    logic       sout_r;
    logic       busy;
    logic       done;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [2:0] M_HOLD = 3'b000, M_LOAD = 3'b001, M_SHL = 3'b010,
                           M_SHR  = 3'b011, M_ROL  = 3'b100, M_ROR = 3'b101,
                           M_ASR  = 3'b110;

    shift_reg_univ #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .mode    (mode),
        .d       (d),
        .sin_l   (sin_l),
        .sin_r   (sin_r),
        .start   (start),
        .amount  (amount),
        .q       (q),
        .sout_l  (sout_l),
        .sout_r  (sout_r),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [2:0] m, input logic [7:0] dv);
        mode = m;
        d    = dv;
        tick();
    endtask

    task automatic check_st(input string tag, input logic [7:0] eq,
                            input logic eb, input logic ed);
        chk({tag, "_q"}, 32'(q), 32'(eq));
        chk({tag, "_busy"}, 32'(busy), 32'(eb));
        chk({tag, "_done"}, 32'(done), 32'(ed));
    endtask

    // Start a burst and wait (bounded) for done; checks step count and final q.
    task automatic run_burst(input string tag, input logic [2:0] m,
                             input logic [3:0] amt, input logic [7:0] eq);
        int n;
        mode   = m;
        amount = amt;
        start  = 1'b1;
        tick();
        start = 1'b0;
        mode  = M_HOLD;
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_len"}, 32'(n), 32'(amt));
        chk({tag, "_q"}, 32'(q), 32'(eq));
    endtask

    initial begin
        reset_n = 1'b0;
        en      = 1'b1;
        mode    = M_LOAD;
        d       = 8'hFF;
        sin_l   = 1'b0;
        sin_r   = 1'b0;
        start   = 1'b0;
        amount  = 4'd0;

        // Reset holds off a load
        tick();
        tick();
        check_st("reset", 8'h00, 1'b0, 1'b0);
        reset_n = 1'b1;
        step(M_LOAD, 8'hA5);
        chk("load_a5", 32'(q), 32'h A5);
        chk("sout_l", 32'(sout_l), 32'd1);
        chk("sout_r", 32'(sout_r), 32'd1);

        // Single steps
        step(M_LOAD, 8'h81);
        step(M_ROL, 8'h00);  chk("rol1", 32'(q), 32'h03);
        step(M_ROR, 8'h00);  chk("ror1", 32'(q), 32'h81);
        step(M_ASR, 8'h00);  chk("asr1", 32'(q), 32'hC0);
        step(M_LOAD, 8'h80);
        sin_r = 1'b1;
        step(M_SHL, 8'h00);  chk("shl1", 32'(q), 32'h01);
        sin_r = 1'b0;
        step(M_LOAD, 8'h01);
        sin_l = 1'b1;
        step(M_SHR, 8'h00);  chk("shr1", 32'(q), 32'h80);
        sin_l = 1'b0;
        chk("sout_r_80", 32'(sout_r), 32'd0);
        step(M_HOLD, 8'h3C); chk("hold", 32'(q), 32'h80);

        // ROL burst of 3
        step(M_LOAD, 8'h01);
        mode = M_ROL; amount = 4'd3; start = 1'b1;
        tick();
        check_st("b3_e0", 8'h01, 1'b1, 1'b0);
        start = 1'b0; mode = M_HOLD;
        tick(); check_st("b3_e1", 8'h02, 1'b1, 1'b0);
        tick(); check_st("b3_e2", 8'h04, 1'b1, 1'b0);
        tick(); check_st("b3_e3", 8'h08, 1'b0, 1'b1);
        tick(); check_st("b3_post", 8'h08, 1'b0, 1'b0);

        // Zero-length burst
        mode = M_ROL; amount = 4'd0; start = 1'b1;
        tick();
        check_st("b0_e0", 8'h08, 1'b0, 1'b1);
        start = 1'b0; mode = M_HOLD;
        tick(); check_st("b0_post", 8'h08, 1'b0, 1'b0);

        // Enable stall inside a ROR burst of 4
        step(M_LOAD, 8'h10);
        mode = M_ROR; amount = 4'd4; start = 1'b1;
        tick();
        start = 1'b0; mode = M_HOLD;
        tick(); check_st("st_e1", 8'h08, 1'b1, 1'b0);
        en = 1'b0;
        tick(); check_st("st_off1", 8'h08, 1'b1, 1'b0);
        tick(); check_st("st_off2", 8'h08, 1'b1, 1'b0);
        en = 1'b1;
        tick(); check_st("st_e2", 8'h04, 1'b1, 1'b0);
        tick(); check_st("st_e3", 8'h02, 1'b1, 1'b0);
        tick(); check_st("st_e4", 8'h01, 1'b0, 1'b1);
        tick(); check_st("st_post", 8'h01, 1'b0, 0);

        // en low on the edge after done clears done
        mode = M_ROL; amount = 4'd1; start = 1'b1;
        tick();
        start = 1'b0; mode = M_HOLD;
        tick(); check_st("b1_e1", 8'h02, 1'b0, 1'b1);
        en = 1'b0;
        tick(); check_st("b1_off", 8'h02, 1'b0, 1'b0);
        en = 1'b1;

        // Reset mid-burst
        step(M_LOAD, 8'hFF);
        mode = M_SHL; amount = 4'd8; start = 1'b1;
        tick();
        start = 1'b0; mode = M_HOLD;
        tick(); tick(); tick();
        check_st("rb_e3", 8'hF8, 1'b1, 1'b0);
        reset_n = 1'b0;
        tick(); check_st("rb_rst", 8'h00, 1'b0, 1'b0);
        reset_n = 1'b1;
        tick(); check_st("rb_after", 8'h00, 1'b0, 1'b0);
        step(M_LOAD, 8'h03);
        run_burst("rb_ror2", M_ROR, 4'd2, 8'hC0);
        tick();

        // Inputs ignored while busy; start with load mode is a plain load
        step(M_LOAD, 8'h01);
        mode = M_ROL; amount = 4'd2; start = 1'b1;
        tick();
        mode = M_LOAD; d = 8'h55; amount = 4'd7;
        tick(); check_st("ig_e1", 8'h02, 1'b1, 1'b0);
        tick(); check_st("ig_e2", 8'h04, 1'b0, 1'b1);
        tick(); check_st("ig_load", 8'h55, 1'b0, 1'b0);
        start = 1'b0;
        step(M_HOLD, 8'h00);

        // Amounts beyond the width
        step(M_LOAD, 8'h00);
        sin_l = 1'b1;
        run_burst("shr9", M_SHR, 4'd9, 8'hFF);
        sin_l = 1'b0;
        tick();
        step(M_LOAD, 8'h01);
        run_burst("rol9", M_ROL, 4'd9, 8'h02);
        tick();
        step(M_LOAD, 8'h80);
        run_burst("asr10", M_ASR, 4'd10, 8'hFF);
        tick();
        step(M_LOAD, 8'h5A);
        sin_r = 1'b0;
        run_burst("shl12", M_SHL, 4'd12, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal register for the sequential flip-flop library: a WIDTH-bit register with synchronous active-low reset, clock enable, parallel load, logical/arithmetic shift and rotate modes. Multi-position shift/rotate bursts run under a start/busy/done handshake, one position per enabled clock. It is the successor to the single-bit D flip-flop and serves as the general storage/serialiser element of the library.

## Interface
- WIDTH, 8, register width in bits; legal range ≥ 2
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset
- AMT_W (localparam), $clog2(WIDTH)+1, width of amount
- clk  input  1  clock; all state changes on rising edge
- reset_n  input  1  synchronous, active-low reset; sampled on clk rising edge, no asynchronous path
- en  input  1  clock enable; 0 freezes q, the state machine and the burst counter
- mode  input  3  operation select (see Operation)
- d  input  WIDTH  parallel load data
- sin_l  input  1  serial in at MSB for logical shift right
- sin_r  input  1  serial in at LSB for shift left
- start  input  1  request a burst of amount steps using mode
- amount  input  AMT_W  burst length in positions
- q  output  WIDTH  register contents
- sout_l  output  1  q[WIDTH-1], combinational from q
- sout_r  output  1  q[0], combinational from q
- busy  output  1  burst in progress
- done  output  1  one-cycle pulse at burst completion

## Operation
- Modes: 000 hold; 001 load q←d; 010 SHL q←{q[W-2:0],sin_r}; 011 SHR q←{sin_l,q[W-1:1]}; 100 ROL q←{q[W-2:0],q[W-1]}; 101 ROR q←{q[0],q[W-1:1]}; 110 ASR q←{q[W-1],q[W-1:1]}; 111 reserved, behaves as hold.
- FSM states: IDLE, BUSY.
- IDLE, en=1, start=0: apply mode once per clock (single-step).
- IDLE, en=1, start=1, mode in 010..110: latch mode and amount; q not modified on this edge; go BUSY if amount>0, else stay IDLE and pulse done.
- IDLE, start=1 with mode 000/001/111: start ignored; treated as single-step.
- BUSY, en=1: apply latched mode once per clock, decrement remaining count; on the edge applying the last step go IDLE, busy←0, done←1.
- BUSY: mode, d, amount, start ignored; sin_l/sin_r sampled live each step.
- en=0 in any state: nothing changes; done forced 0 on that edge (pulse not extended).
- Amount > WIDTH accepted verbatim: logical shifts then fully replace q with serial input, rotates wrap modulo WIDTH, ASR saturates to all-sign.
- Priority per edge: reset_n=0 > BUSY step > start > single-step.

## Timing
- Reset (reset_n=0 at an edge): q=RESET_VAL, busy=0, done=0, state IDLE, counter 0; effective mid-burst, pending burst discarded.
- Single-step latency: 1 clock (result on q after the sampling edge).
- Burst of N≥1, all en=1: start edge E0; busy=1 after E0; steps at E1..EN; after EN busy=0, done=1 for exactly one cycle, q holds final value.
- Burst of N=0: done=1 for one cycle after E0, busy never asserts, q unchanged.
- New start may be sampled on the edge following done (back-to-back bursts, busy low for the done cycle).
- sout_l/sout_r change with q, no added latency.

## Test plan
- Reset: drive reset_n=0 for 2 edges with d=8'hFF, mode=001 -> q=8'h00, busy=0, done=0; release and load 8'hA5 -> q=8'hA5 next cycle.
- Single-step: q=8'h81, ROL once -> 8'h03; ROR once -> 8'h81; ASR -> 8'hC0; SHL with sin_r=1 from 8'h80 -> 8'h01; SHR with sin_l=1 from 8'h01 -> 8'h80.
- Burst: q=8'h01, start with ROL, amount=3 -> busy high 3 cycles, q=8'h02,8'h04,8'h08, done one pulse with busy low; amount=0 -> done after 1 edge, q unchanged.
- Enable stall: ROR burst amount=4 from 8'h10, en=0 for 2 cycles after first step -> q frozen at 8'h08, busy stays 1, completes at 8'h01 after 6 edges total, single done pulse.
- Reset mid-burst: SHL amount=8 from 8'hFF, reset_n=0 after 3 steps -> q=RESET_VAL, busy=0, no done; later start accepted normally.
- Ignored inputs: during a burst, toggle start, mode=001, d=8'h55 -> no load, burst completes unchanged; start with mode=001 in IDLE -> plain load, busy stays 0.
